gate_unit_arbiter: RTL
======================

Name: gate_unit_arbiter

Overview:
- Shares one registered logic-gate unit among N_REQ requesters.
- Unit ops: pass (double NOT), NOT, OR, NOR.
- Round-robin arbitration; fixed 3-cycle req-to-done sequence per transaction.
- Sits between requester blocks and the shared gate datapath, owning grant, operand capture and result return.

Parameters:
N_REQ, 4, number of requesters (2..8)
W, 8, operand/result width in bits

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level
op  in  2*N_REQ  per-requester op code, requester i at bits [2i+1:2i]
a_in  in  W*N_REQ  operand A, requester i at [W*i+W-1:W*i]
b_in  in  W*N_REQ  operand B, same packing
gnt  out  N_REQ  one-hot grant, high through EXEC and RESP
done  out  N_REQ  one-hot, one-cycle result-valid pulse
result  out  W  shared result bus, registered
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at a clk edge) forces:
  - state=IDLE, gnt=0, done=0, result=0, busy=0, rr_ptr=0.
  - Reset overrides every other event in the same cycle.
- Op encoding:
  - 00 PASS: result = ~~a = a
  - 01 NOT: result = ~a
  - 10 OR: result = a|b
  - 11 NOR: result = ~(a|b)
  - All bitwise, width W, no carries.
- States: IDLE, EXEC, RESP (2-bit encoding).
- IDLE:
  - If req != 0: pick winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - At the edge: latch op/a/b of the winner, set gnt[winner]=1, store idx, go EXEC.
  - If req == 0: stay IDLE, outputs 0.
- EXEC:
  - result <= f(op_q, a_q, b_q); go RESP. gnt held.
- RESP:
  - done[idx]=1 for exactly this cycle; result valid.
  - At the edge: gnt=0, done=0, rr_ptr <= (idx+1) mod N_REQ, go IDLE.
- Latency: req seen in IDLE at edge t -> gnt visible t+1, done/result at t+2, IDLE at t+3.
- Throughput: one op per 3 cycles; at most one transaction in flight.
- Operands sampled only at grant edge; later changes to a_in/b_in/op are ignored.
- req dropped during EXEC/RESP is ignored: transaction completes, done still pulses.
- req still high in the IDLE cycle after RESP is treated as a new request and competes under the advanced rr_ptr.
  - A continuously requesting master cannot starve others.
- result holds its last value between transactions; it is cleared only by rst.
- Simultaneous requests: winner is strictly rotating priority from rr_ptr; losers wait, no lost requests while req held.
- Wrap: rr_ptr = N_REQ-1 advancing yields 0.
- rst during EXEC/RESP: transaction abandoned, no done pulse, result=0.

Decomposition:
- Package gate_unit_pkg:
  - OP_PASS/OP_NOT/OP_OR/OP_NOR 2-bit constants.
  - State typedef (IDLE/EXEC/RESP).
  - Function gate_eval(op, a, b) used by both RTL and bench model.
- One sub-module: gate_unit_rr_pick.
  - Combinational rotating-priority picker: req and rr_ptr in, one-hot grant and binary idx out.
- Top holds FSM, operand registers, result register, rr_ptr.

Test Plan:
- Only req[2] high, op=01, a=0xA5, rr_ptr=0 after reset -> gnt=0b0100 at t+1, done=0b0100 and result=0x5A at t+2, busy low at t+3.
- All four req held high from reset, op per i = PASS/NOT/OR/NOR, a=0x0F, b=0xF0:
  - grant order 0,1,2,3,0, each 3 cycles apart.
  - results 0x0F, 0xF0, 0xFF, 0x00.
- Wrap: after serving req 3, assert req[0] and req[3] together -> req[0] granted first, then req[3].
- Operand change after grant: a_in[1] switches 0x33->0xCC in EXEC, op=00 -> result=0x33.
- req[1] dropped in EXEC cycle -> done[1] still pulses at t+2; no further grant to 1.
- rst asserted in EXEC -> next cycle gnt=0, done stays 0 throughout, result=0, state IDLE, rr_ptr=0.

Source files
------------

// File: rtl/gate_unit_pkg.sv
// Shared definitions for the gate-unit arbiter: op codes, FSM states and the
// bitwise evaluation function of the shared gate datapath.
package gate_unit_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  // Operands are carried at the widest supported width and truncated by the caller.
  localparam int GW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [GW-1:0] gate_eval(input logic [1:0] op,
                                              input logic [GW-1:0] a,
                                              input logic [GW-1:0] b);
    logic [GW-1:0] r;
    case (op)
      OP_PASS: r = ~(~a);
      OP_NOT:  r = ~a;
      OP_OR:   r = a | b;
      default: r = ~(a | b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_unit_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or after
// rr_ptr (wrapping) wins; gives a one-hot grant and its binary index.
module gate_unit_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one registered gate unit among N_REQ requesters;
// each transaction runs IDLE -> EXEC -> RESP with operands captured at grant.
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op,
  input  logic [W*N_REQ-1:0] a_in,
  input  logic [W*N_REQ-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       result,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic [W-1:0]     result_reg, result_next;
  logic [IW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [1:0]       op_q_reg, op_q_next;
  logic [W-1:0]     a_q_reg, a_q_next;
  logic [W-1:0]     b_q_reg, b_q_next;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;

  logic [1:0]       op_arr [N_REQ];
  logic [W-1:0]     a_arr  [N_REQ];
  logic [W-1:0]     b_arr  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign op_arr[gi] = op[2*gi +: 2];
      assign a_arr[gi]  = a_in[W*gi +: W];
      assign b_arr[gi]  = b_in[W*gi +: W];
    end
  endgenerate

  gate_unit_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      done_reg   <= '0;
      result_reg <= '0;
      rr_ptr_reg <= '0;
      idx_reg    <= '0;
      op_q_reg   <= '0;
      a_q_reg    <= '0;
      b_q_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      result_reg <= result_next;
      rr_ptr_reg <= rr_ptr_next;
      idx_reg    <= idx_next;
      op_q_reg   <= op_q_next;
      a_q_reg    <= a_q_next;
      b_q_reg    <= b_q_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    gnt_next    = gnt_reg;
    done_next   = done_reg;
    result_next = result_reg;
    rr_ptr_next = rr_ptr_reg;
    idx_next    = idx_reg;
    op_q_next   = op_q_reg;
    a_q_next    = a_q_reg;
    b_q_next    = b_q_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next   = pick_gnt;
          idx_next   = pick_idx;
          op_q_next  = op_arr[pick_idx];
          a_q_next   = a_arr[pick_idx];
          b_q_next   = b_arr[pick_idx];
          state_next = EXEC;
        end
      end
      EXEC: begin
        result_next = W'(gate_eval(op_q_reg, GW'(a_q_reg), GW'(b_q_reg)));
        done_next   = gnt_reg;
        state_next  = RESP;
      end
      RESP: begin
        gnt_next    = '0;
        done_next   = '0;
        rr_ptr_next = (idx_reg == IW'(N_REQ - 1)) ? '0 : idx_reg + 1'b1;
        state_next  = IDLE;
      end
      default: begin
        gnt_next   = '0;
        done_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign gnt    = gnt_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign busy   = (state_reg != IDLE);

endmodule
